// File: rtl/float_pkg.sv
`default_nettype none
// float_pkg -- rounding-mode encoding and round-up decision shared by the normalizer (rev 1.0)
package float_pkg;

  localparam int RM_W = 3;

  typedef enum logic [RM_W-1:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  // Unlisted encodings fall through to round-to-nearest-even.
  function automatic logic round_up(input logic [RM_W-1:0] rm, input logic sign,
                                    input logic lsb, input logic guard, input logic sticky);
    logic up;
    case (rm)
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = sign & (guard | sticky);
      RM_RUP:  up = ~sign & (guard | sticky);
      RM_RMM:  up = guard;
      default: up = guard & (sticky | lsb);
    endcase
    return up;
  endfunction

endpackage
`default_nettype wire

// File: rtl/float_rounder.sv
`default_nettype none
// float_rounder -- combinational rounding of a truncated mantissa with carry-out renormalization (rev 1.0)
module float_rounder
  import float_pkg::*;
#(
  parameter int N  = 24,
  parameter int PW = 7
) (
  input  logic [N-1:0]    t,
  input  logic            guard,
  input  logic            sticky,
  input  logic            sign,
  input  logic [RM_W-1:0] rm,
  input  logic [PW-1:0]   p,
  output logic [N-1:0]    y,
  output logic [PW-1:0]   msb_pos,
  output logic            inexact
);

  logic [N:0] sum;

  always_comb begin
    sum = {1'b0, t} + {{N{1'b0}}, round_up(rm, sign, t[0], guard, sticky)};
    // An all-ones mantissa rounding up becomes 1.000... one binade higher.
    if (sum[N]) begin
      y       = {1'b1, {(N-1){1'b0}}};
      msb_pos = p + PW'(1);
    end else begin
      y       = sum[N-1:0];
      msb_pos = p;
    end
    inexact = guard | sticky;
  end

endmodule
`default_nettype wire

// File: rtl/float_normalizer_pipe.sv
`default_nettype none
// float_normalizer_pipe -- two-stage normalize-and-round of an unsigned magnitude (rev 1.0)
module float_normalizer_pipe
  import float_pkg::*;
#(
  parameter int N    = 24,
  parameter int IN_W = 2 * N,
  parameter int PW   = $clog2(IN_W) + 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] A,
  input  logic            sign,
  input  logic [RM_W-1:0] rm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    Y,
  output logic [PW-1:0]   msb_pos,
  output logic            inexact,
  output logic            zero
);

  localparam int EW = IN_W + N - 1;

  logic            en;
  logic [PW-1:0]   lead_pos;
  logic [EW-1:0]   ext;
  logic [EW-1:0]   gmask;
  logic [EW-1:0]   smask;
  logic [N-1:0]    t_in;
  logic            guard_in;
  logic            sticky_in;
  logic            zero_in;

  logic            s1_valid;
  logic [N-1:0]    s1_t;
  logic            s1_guard;
  logic            s1_sticky;
  logic            s1_sign;
  logic [RM_W-1:0] s1_rm;
  logic [PW-1:0]   s1_pos;
  logic            s1_zero;

  logic [N-1:0]    rnd_y;
  logic [PW-1:0]   rnd_pos;
  logic            rnd_inexact;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (A[i]) lead_pos = PW'(i);
    end
    // Append N-1 zeros so a leading one anywhere lands at bit N-1 after the shift.
    ext       = {A, {(N-1){1'b0}}};
    t_in      = N'(ext >> lead_pos);
    gmask     = (lead_pos == '0) ? '0 : (EW'(1) << (lead_pos - PW'(1)));
    smask     = gmask - EW'(1);
    guard_in  = |(ext & gmask);
    sticky_in = (lead_pos != '0) && (|(ext & smask));
    zero_in   = (A == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_t      <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_sign   <= 1'b0;
      s1_rm     <= '0;
      s1_pos    <= '0;
      s1_zero   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_t      <= t_in;
        s1_guard  <= guard_in;
        s1_sticky <= sticky_in;
        s1_sign   <= sign;
        s1_rm     <= rm;
        s1_pos    <= lead_pos;
        s1_zero   <= zero_in;
      end
    end
  end

  float_rounder #(
    .N  (N),
    .PW (PW)
  ) u_rounder (
    .t       (s1_t),
    .guard   (s1_guard),
    .sticky  (s1_sticky),
    .sign    (s1_sign),
    .rm      (s1_rm),
    .p       (s1_pos),
    .y       (rnd_y),
    .msb_pos (rnd_pos),
    .inexact (rnd_inexact)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      Y         <= '0;
      msb_pos   <= '0;
      inexact   <= 1'b0;
      zero      <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Y       <= rnd_y;
        msb_pos <= rnd_pos;
        inexact <= rnd_inexact;
        zero    <= s1_zero;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float_normalizer_pipe.sv
`default_nettype none
// tb_float_normalizer_pipe -- self-checking bench for the N=4, IN_W=8 normalizer (rev 1.0)
module tb_float_normalizer_pipe;
  import float_pkg::*;

  localparam int N    = 4;
  localparam int IN_W = 8;
  localparam int PW   = $clog2(IN_W) + 1;

  typedef struct packed {
    logic [N-1:0]  y;
    logic [PW-1:0] mp;
    logic          inx;
    logic          z;
  } res_t;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] A = '0;
  logic            sign = 1'b0;
  logic [2:0]      rm = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N-1:0]    Y;
  logic [PW-1:0]   msb_pos;
  logic            inexact;
  logic            zero;

  int checks = 0;
  int failures = 0;

  logic [IN_W-1:0] qa[$];
  logic [2:0]      qr[$];
  logic            qs[$];

  float_normalizer_pipe #(.N(N), .IN_W(IN_W), .PW(PW)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .sign(sign), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .msb_pos(msb_pos), .inexact(inexact), .zero(zero)
  );

  always #5 clock = ~clock;

  // Reference: exact rational arithmetic on A * 2^(N-1) / 2^p.
  function automatic res_t model(input logic [IN_W-1:0] a, input logic [2:0] m, input logic s);
    res_t r;
    longint p, scaled, t, rem, half;
    logic g, st, up;
    r = '0;
    if (a == 0) begin
      r.z = 1'b1;
      return r;
    end
    p = 0;
    for (longint v = longint'(a); v > 1; v = v / 2) p++;
    scaled = longint'(a) * (longint'(1) << (N - 1));
    t      = scaled / (longint'(1) << p);
    rem    = scaled % (longint'(1) << p);
    g = 1'b0;
    st = 1'b0;
    if (p > 0) begin
      half = longint'(1) << (p - 1);
      g    = (rem >= half);
      st   = ((rem % half) != 0);
    end
    case (m)
      3'd1:    up = 1'b0;
      3'd2:    up = s && (g || st);
      3'd3:    up = !s && (g || st);
      3'd4:    up = g;
      default: up = g && (st || (t % 2 == 1));
    endcase
    t = t + longint'(up);
    if (t == (longint'(1) << N)) begin
      r.y  = N'(longint'(1) << (N - 1));
      r.mp = PW'(p + 1);
    end else begin
      r.y  = N'(t);
      r.mp = PW'(p);
    end
    r.inx = g || st;
    return r;
  endfunction

  task automatic send_one(input logic [IN_W-1:0] a, input logic [2:0] m, input logic s);
    @(negedge clock);
    A = a; rm = m; sign = s; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; A = 8'hFF; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({out_valid, Y, msb_pos, inexact, zero, in_ready} !== {1'b0, {N{1'b0}}, {PW{1'b0}}, 3'b001}) begin
        failures++;
        $display("FAIL reset_state: got %b expected all-zero with in_ready=1",
                 {out_valid, Y, msb_pos, inexact, zero, in_ready});
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [IN_W-1:0] da[7] = '{8'h05, 8'hB8, 8'hB8, 8'hF8, 8'hB9, 8'hB9, 8'h00};
    logic [2:0]      dr[7] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd3};
    logic            ds[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    res_t            de[7] = '{'{4'b1010, 4'd2, 1'b0, 1'b0}, '{4'b1100, 4'd7, 1'b1, 1'b0},
                               '{4'b1011, 4'd7, 1'b1, 1'b0}, '{4'b1000, 4'd8, 1'b1, 1'b0},
                               '{4'b1100, 4'd7, 1'b1, 1'b0}, '{4'b1011, 4'd7, 1'b1, 1'b0},
                               '{4'b0000, 4'd0, 1'b0, 1'b1}};
    for (int i = 0; i < 7; i++) begin
      send_one(da[i], dr[i], ds[i]);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL directed_valid[%0d]: out_valid=%b expected 1", i, out_valid);
      end
      checks++;
      if ({Y, msb_pos, inexact, zero} !== de[i]) begin
        failures++;
        $display("FAIL directed[%0d] A=%h rm=%0d: got Y=%b msb=%0d inx=%b z=%b expected Y=%b msb=%0d inx=%b z=%b",
                 i, da[i], dr[i], Y, msb_pos, inexact, zero, de[i].y, de[i].mp, de[i].inx, de[i].z);
      end
    end
  endtask

  // Streams the beats queued in qa/qr/qs with random bubbles and backpressure.
  task automatic test_stream(input string name, input int ready_pct);
    res_t expq[$];
    res_t e;
    logic [N+PW+1:0] held = '0;
    logic stalled = 1'b0;
    int total = qa.size();
    int sent = 0, got = 0, cyc = 0;
    while (got < total && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      if (stalled) begin
        checks++;
        if ({Y, msb_pos, inexact, zero} !== held) begin
          failures++;
          $display("FAIL %s_stall_stable: got %h expected %h", name, {Y, msb_pos, inexact, zero}, held);
        end
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (sent < total) begin
        in_valid = ($urandom_range(0, 3) != 0);
        A = qa[sent]; rm = qr[sent]; sign = qs[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        expq.push_back(model(A, rm, sign));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL %s_extra: got unexpected output %h expected none", name, {Y, msb_pos, inexact, zero});
        end else begin
          e = expq.pop_front();
          if ({Y, msb_pos, inexact, zero} !== e) begin
            failures++;
            $display("FAIL %s_data[%0d]: got Y=%b msb=%0d inx=%b z=%b expected Y=%b msb=%0d inx=%b z=%b",
                     name, got, Y, msb_pos, inexact, zero, e.y, e.mp, e.inx, e.z);
          end
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held = {Y, msb_pos, inexact, zero};
    end
    checks++;
    if (got != total || expq.size() != 0) begin
      failures++;
      $display("FAIL %s_count: got %0d outputs expected %0d", name, got, total);
    end
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    qa.delete(); qr.delete(); qs.delete();
    for (int i = 1; i <= 20; i++) begin
      qa.push_back(IN_W'(i));
      qr.push_back(3'($urandom_range(0, 7)));
      qs.push_back(1'($urandom_range(0, 1)));
    end
    test_stream("backpressure", 50);
  endtask

  task automatic test_sweep();
    qa.delete(); qr.delete(); qs.delete();
    for (int m = 0; m < 8; m++) begin
      for (int a = 0; a < 256; a++) begin
        qa.push_back(IN_W'(a));
        qr.push_back(3'(m));
        qs.push_back(1'($urandom_range(0, 1)));
      end
    end
    test_stream("sweep", 80);
  endtask

  task automatic test_midreset();
    @(negedge clock);
    A = 8'h05; rm = 3'd0; sign = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    A = 8'hB8;
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL midreset_inflight: out_valid=%b expected 1", out_valid);
    end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    checks++;
    if ({out_valid, Y, msb_pos, inexact, zero} !== '0) begin
      failures++;
      $display("FAIL midreset_clear: got %b expected 0", {out_valid, Y, msb_pos, inexact, zero});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset_discard[%0d]: out_valid=%b expected 0", i, out_valid);
      end
    end
    A = 8'hF8; rm = 3'd0; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_early: out_valid=%b expected 0 after one edge", out_valid);
    end
    @(negedge clock);
    checks++;
    if ({out_valid, Y, msb_pos, inexact, zero} !== {1'b1, 4'b1000, 4'd8, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL midreset_first: got %b expected %b", {out_valid, Y, msb_pos, inexact, zero},
               {1'b1, 4'b1000, 4'd8, 1'b1, 1'b0});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_sweep();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
